// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between a requester and apb_mem_slave.
// Signal suffixes are written from the slave's point of view.
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  psel_i;
  logic                  penable_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic                  pwrite_i;
  logic [DATA_WIDTH-1:0] pwdata_i;
  logic [DATA_WIDTH-1:0] prdata_o;
  logic                  pready_o;
  logic                  pslverr_o;

  modport master (
    output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB slave: word memory plus CTRL/WR_CNT/RD_CNT registers, with a
// programmable number of wait states on every transfer.
//
// state  | meaning
// IDLE   | waiting for a setup phase (psel=1, penable=0)
// ACCESS | transfer decoded; counting wait states, then completing
module apb_mem_slave #(
  parameter int       ADDR_WIDTH    = 32,
  parameter int       DATA_WIDTH    = 32,
  parameter int       MEM_DEPTH_LG2 = 8,
  parameter bit [3:0] RESET_WAIT    = 4'd0
) (
  input  logic         clk,
  input  logic         rst,
  apb_mem_slave_if.slave apb
);
  localparam int MEM_WORDS = 1 << MEM_DEPTH_LG2;

  typedef enum logic { IDLE, ACCESS } state_e;
  typedef enum logic [1:0] { TGT_MEM, TGT_CTRL, TGT_WRCNT, TGT_RDCNT } tgt_e;

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  tgt_e                     tgt_q, tgt_d;
  logic [MEM_DEPTH_LG2-1:0] idx_q, idx_d;
  logic                     write_q, write_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     err_q, err_d;
  logic [DATA_WIDTH-1:0]    prdata_q, prdata_d;
  logic [3:0]               wait_q, wait_d;
  logic [15:0]              wr_cnt_q, wr_cnt_d;
  logic [15:0]              rd_cnt_q, rd_cnt_d;
  logic                     mem_we;

  logic [DATA_WIDTH-1:0]    mem [MEM_WORDS];

  logic [15:0]              a16;
  logic [MEM_DEPTH_LG2-1:0] dec_idx;
  tgt_e                     dec_tgt;
  logic                     dec_err;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     unused_addr_hi;

  assign a16            = apb.paddr_i[15:0];
  assign dec_idx        = apb.paddr_i[MEM_DEPTH_LG2+1:2];
  assign unused_addr_hi = ^apb.paddr_i[ADDR_WIDTH-1:16];

  always_comb begin
    dec_tgt = TGT_MEM;
    dec_err = 1'b0;
    if (a16[1:0] != 2'b00) begin
      dec_err = 1'b1;
    end else if ((a16 >> (MEM_DEPTH_LG2 + 2)) == 16'd0) begin
      dec_tgt = TGT_MEM;
    end else if (a16 == 16'hF000) begin
      dec_tgt = TGT_CTRL;
    end else if (a16 == 16'hF004) begin
      dec_tgt = TGT_WRCNT;
      dec_err = apb.pwrite_i;
    end else if (a16 == 16'hF008) begin
      dec_tgt = TGT_RDCNT;
      dec_err = apb.pwrite_i;
    end else begin
      dec_err = 1'b1;
    end
  end

  always_comb begin
    rd_word = '0;
    case (dec_tgt)
      TGT_MEM:   rd_word = mem[dec_idx];
      TGT_CTRL:  rd_word = DATA_WIDTH'(wait_q);
      TGT_WRCNT: rd_word = DATA_WIDTH'(wr_cnt_q);
      TGT_RDCNT: rd_word = DATA_WIDTH'(rd_cnt_q);
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tgt_q    <= TGT_MEM;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      wait_q   <= RESET_WAIT;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      wait_q   <= wait_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    wait_d   = wait_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb.psel_i && !apb.penable_i) begin
          state_d  = ACCESS;
          tgt_d    = dec_tgt;
          idx_d    = dec_idx;
          write_d  = apb.pwrite_i;
          wdata_d  = apb.pwdata_i;
          err_d    = dec_err;
          prdata_d = (dec_err || apb.pwrite_i) ? '0 : rd_word;
          cnt_d    = wait_q;
        end
      end
      ACCESS: begin
        if (!apb.psel_i) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (apb.penable_i) begin
          state_d = IDLE;
          if (!err_q) begin
            if (write_q) begin
              wr_cnt_d = wr_cnt_q + 16'd1;
              if (tgt_q == TGT_MEM) begin
                mem_we = 1'b1;
              end else if (tgt_q == TGT_CTRL) begin
                wait_d = wdata_q[3:0];
              end
            end else begin
              rd_cnt_d = rd_cnt_q + 16'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only.
  always_comb begin
    apb.pready_o  = (state_q == ACCESS) && (cnt_q == 4'd0);
    apb.prdata_o  = apb.pready_o ? prdata_q : '0;
    apb.pslverr_o = apb.pready_o & err_q;
  end
endmodule
